// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with horizontal and vertical phase FSMs and registered sync/blank/frame_start.
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  phase_t     h_state_reg, h_state_next;
  phase_t     v_state_reg, v_state_next;
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic       h_wrap;
  logic       hs_reg, hs_next;
  logic       vs_reg, vs_next;
  logic       blank_reg, blank_next;
  logic       fs_reg, fs_next;

  // Reset parks everything on the last pixel of the frame so the first
  // enabled cycle lands cleanly on (0,0).
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      h_state_reg <= PH_BACK;
      v_state_reg <= PH_BACK;
      x_reg       <= H_LAST;
      y_reg       <= V_LAST;
      hs_reg      <= 1'b1;
      vs_reg      <= 1'b1;
      blank_reg   <= 1'b0;
      fs_reg      <= 1'b0;
    end else if (pix_ce) begin
      h_state_reg <= h_state_next;
      v_state_reg <= v_state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      hs_reg      <= hs_next;
      vs_reg      <= vs_next;
      blank_reg   <= blank_next;
      fs_reg      <= fs_next;
    end
  end

  always_comb begin
    h_wrap = (x_reg == H_LAST);
    x_next = h_wrap ? 10'd0 : x_reg + 10'd1;
    y_next = y_reg;
    if (h_wrap) begin
      y_next = (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
    end

    h_state_next = h_state_reg;
    case (h_state_reg)
      PH_ACTIVE: if (x_next == H_FP_START)   h_state_next = PH_FRONT;
      PH_FRONT:  if (x_next == H_SYNC_START) h_state_next = PH_SYNC;
      PH_SYNC:   if (x_next == H_BP_START)   h_state_next = PH_BACK;
      PH_BACK:   if (x_next == 10'd0)        h_state_next = PH_ACTIVE;
      default:                               h_state_next = PH_BACK;
    endcase

    // The vertical FSM only looks at DrawY on the line wrap.
    v_state_next = v_state_reg;
    if (h_wrap) begin
      case (v_state_reg)
        PH_ACTIVE: if (y_next == V_FP_START)   v_state_next = PH_FRONT;
        PH_FRONT:  if (y_next == V_SYNC_START) v_state_next = PH_SYNC;
        PH_SYNC:   if (y_next == V_BP_START)   v_state_next = PH_BACK;
        PH_BACK:   if (y_next == 10'd0)        v_state_next = PH_ACTIVE;
        default:                               v_state_next = PH_BACK;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered values line
  // up with the registered DrawX/DrawY.
  always_comb begin
    hs_next    = (h_state_next != PH_SYNC);
    vs_next    = (v_state_next != PH_SYNC);
    blank_next = (h_state_next == PH_ACTIVE) && (v_state_next == PH_ACTIVE);
    fs_next    = (x_next == 10'd0) && (y_next == 10'd0);
  end

  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign blank       = blank_reg;
  assign DrawX       = x_reg;
  assign DrawY       = y_reg;
  assign frame_start = fs_reg;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_reg;
  logic        frame_seen_reg;

  // The first frame after reset reads 0; later frame starts count up.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      frame_cnt_reg  <= 16'd0;
      frame_seen_reg <= 1'b0;
    end else if (pix_ce && fs_next) begin
      frame_seen_reg <= 1'b1;
      if (frame_seen_reg) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-timing instance for reset and line timing, and a
// small-geometry instance (32x19 total) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_ce  = 1'b0;

  always #5 vga_clk = ~vga_clk;

  // default 640x480 instance
  logic       f_hs, f_vs, f_blank, f_fs;
  logic [9:0] f_x, f_y;
  // scaled instance: H 16/4/8/4 (total 32), V 12/2/2/3 (total 19)
  logic       hs, vs, blank, fs;
  logic [9:0] x, y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] f_fcnt, fcnt;
`endif

  vga_timing_gen dut_full (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .hs          (f_hs),
    .vs          (f_vs),
    .blank       (f_blank),
    .DrawX       (f_x),
    .DrawY       (f_y),
    .frame_start (f_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (f_fcnt)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .DrawX       (x),
    .DrawY       (y),
    .frame_start (fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt   (fcnt)
`endif
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  int vs_low, hs_low, blank_cnt, max_x, max_y, vs_fall_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("chk %-16s obs=%0d exp=%0d", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Steps the scaled instance until the next frame_start, gathering frame statistics.
  task automatic to_frame_start(input int limit, output int clocks);
    logic prev_vs;
    prev_vs   = vs;
    clocks    = 0;
    vs_low    = 0;
    hs_low    = 0;
    blank_cnt = 0;
    max_x     = 0;
    max_y     = 0;
    vs_fall_y = -1;
    do begin
      tick();
      clocks++;
      if (!vs) vs_low++;
      if (!hs) hs_low++;
      if (blank) blank_cnt++;
      if (int'(x) > max_x) max_x = int'(x);
      if (int'(y) > max_y) max_y = int'(y);
      if (prev_vs && !vs) vs_fall_y = int'(y);
      prev_vs = vs;
    end while (!fs && clocks < limit);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int clocks, fall_x, rise_x, low_cnt, vlow_cnt, hold_err, move_err, found;
    logic prev_hs, done;
    logic [23:0] snap;

    // Reset with pix_ce low: reset must win regardless of the enable.
    reset_n = 1'b0;
    pix_ce  = 1'b0;
    repeat (3) tick();
    check("rst_full_x", f_x, 799);
    check("rst_full_y", f_y, 524);
    check("rst_full_hs", f_hs, 1);
    check("rst_full_vs", f_vs, 1);
    check("rst_full_blank", f_blank, 0);
    check("rst_full_fs", f_fs, 0);
    check("rst_s_x", x, 31);
    check("rst_s_y", y, 18);

    reset_n = 1'b1;
    pix_ce  = 1'b1;
    tick();
    check("first_full_x", f_x, 0);
    check("first_full_y", f_y, 0);
    check("first_full_blank", f_blank, 1);
    check("first_full_fs", f_fs, 1);
    check("first_s_blank", blank, 1);
    check("first_s_fs", fs, 1);
`ifdef VGA_FRAME_COUNT_EN
    check("first_full_fcnt", f_fcnt, 0);
`endif

    // One full line of the default instance: sync window 656..751.
    prev_hs  = f_hs;
    fall_x   = -1;
    rise_x   = -1;
    low_cnt  = 0;
    vlow_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (!f_hs) low_cnt++;
      if (!f_vs) vlow_cnt++;
      if (prev_hs && !f_hs) fall_x = int'(f_x);
      if (!prev_hs && f_hs) rise_x = int'(f_x);
      prev_hs = f_hs;
    end
    check("hs_fall_x", fall_x, 656);
    check("hs_rise_x", rise_x, 752);
    check("hs_low_cycles", low_cnt, 96);
    check("vs_line0_low", vlow_cnt, 0);
    check("line_wrap_x", f_x, 0);
    check("line_wrap_y", f_y, 1);

    // Restart the scaled instance from a fresh reset for frame-level checks.
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("s_start_x", x, 0);
    check("s_start_y", y, 0);
    check("s_start_fs", fs, 1);
`ifdef VGA_FRAME_COUNT_EN
    check("fcnt_frame0", fcnt, 0);
`endif

    to_frame_start(2000, clocks);
    check("frame_period", clocks, 608);
    check("vs_low_cycles", vs_low, 64);
    check("vs_fall_y", vs_fall_y, 14);
    check("hs_low_frame", hs_low, 152);
    check("blank_cycles", blank_cnt, 192);
    check("max_x", max_x, 31);
    check("max_y", max_y, 18);
`ifdef VGA_FRAME_COUNT_EN
    check("fcnt_frame1", fcnt, 1);
`endif

    to_frame_start(2000, clocks);
    check("frame_period2", clocks, 608);
`ifdef VGA_FRAME_COUNT_EN
    check("fcnt_frame2", fcnt, 2);
`endif

    // pix_ce toggling 0/1: outputs hold on disabled edges, frame takes 2x clocks.
    clocks   = 0;
    done     = 1'b0;
    hold_err = 0;
    move_err = 0;
    while (!done && clocks < 3000) begin
      pix_ce = ((clocks % 2) == 1);
      snap   = {hs, vs, blank, fs, y, x};
      tick();
      clocks++;
      if (!pix_ce && ({hs, vs, blank, fs, y, x} !== snap)) hold_err++;
      if (pix_ce && (x === snap[9:0])) move_err++;
      if (pix_ce && fs) done = 1'b1;
    end
    check("ce_frame_clocks", clocks, 1216);
    check("ce_hold_errors", hold_err, 0);
    check("ce_move_errors", move_err, 0);
`ifdef VGA_FRAME_COUNT_EN
    check("fcnt_frame3", fcnt, 3);
`endif

    // Reset in the middle of a vertical sync pulse.
    pix_ce = 1'b1;
    found  = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick();
      if (x == 10'd24 && y == 10'd14) found = 1;
    end
    check("mid_point_found", found, 1);
    check("mid_vs_low", vs, 0);
    check("mid_hs_low", hs, 0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_x", x, 31);
    check("mid_rst_y", y, 18);
    check("mid_rst_hs", hs, 1);
    check("mid_rst_vs", vs, 1);
    check("mid_rst_blank", blank, 0);
    check("mid_rst_fs", fs, 0);
    check("mid_rst_full_x", f_x, 799);
    check("mid_rst_full_y", f_y, 524);
    reset_n = 1'b1;
    tick();
    check("post_rst_x", x, 0);
    check("post_rst_y", y, 0);
    check("post_rst_fs", fs, 1);
`ifdef VGA_FRAME_COUNT_EN
    check("post_rst_fcnt", fcnt, 0);
`endif
    to_frame_start(2000, clocks);
    check("post_rst_period", clocks, 608);
    check("post_rst_vs_low", vs_low, 64);
    check("post_rst_vs_fall", vs_fall_y, 14);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
